// File: rtl/stark_pkg.sv
// Shared types and constants for the Stark branch resolution unit.
package stark_pkg;

    localparam int unsigned ROB_W    = 5;
    localparam int unsigned CP_W     = 3;
    localparam int unsigned PREG_W   = 7;
    localparam int unsigned INSN_LEN = 4;

    typedef logic [ROB_W-1:0]  rob_ndx_t;
    typedef logic [CP_W-1:0]   checkpt_ndx_t;
    typedef logic [PREG_W-1:0] pregno_t;

    typedef enum logic [2:0] {
        COND_EQ     = 3'd0,
        COND_NE     = 3'd1,
        COND_LT     = 3'd2,
        COND_GE     = 3'd3,
        COND_LTU    = 3'd4,
        COND_GEU    = 3'd5,
        COND_ALWAYS = 3'd6,
        COND_NEVER  = 3'd7
    } br_cond_t;

    typedef enum logic [2:0] {
        BTS_NONE = 3'd0,
        BTS_BCC  = 3'd1,
        BTS_JMP  = 3'd2,
        BTS_JSR  = 3'd3,
        BTS_RET  = 3'd4
    } bts_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EVAL    = 2'd1,
        ST_RESTART = 2'd2
    } br_state_t;

endpackage

// File: rtl/stark_branch_cmp.sv
// Combinational branch condition evaluator over full-width operands.
module stark_branch_cmp
    import stark_pkg::*;
#(
    parameter int unsigned VWID = 64
) (
    input  logic [VWID-1:0] a,
    input  logic [VWID-1:0] b,
    input  logic [2:0]      cond,
    output logic            hit_c
);

    always_comb begin
        hit_c = 1'b0;
        case (br_cond_t'(cond))
            COND_EQ:     hit_c = (a == b);
            COND_NE:     hit_c = (a != b);
            COND_LT:     hit_c = ($signed(a) <  $signed(b));
            COND_GE:     hit_c = ($signed(a) >= $signed(b));
            COND_LTU:    hit_c = (a <  b);
            COND_GEU:    hit_c = (a >= b);
            COND_ALWAYS: hit_c = 1'b1;
            default:     hit_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/stark_branch_resolve.sv
// Two-stage branch resolver: E1 evaluates condition and target, E2 checks the
// prediction, completes to the ROB and raises a held restart request on mispredict.
module stark_branch_resolve
    import stark_pkg::*;
#(
    parameter int unsigned AWID     = 32,
    parameter int unsigned VWID     = 64,
    parameter int unsigned INSN_LEN = stark_pkg::INSN_LEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    input  rob_ndx_t           id_i,
    input  checkpt_ndx_t       cp_i,
    input  logic [AWID-1:0]    pc_i,
    input  logic [VWID-1:0]    argA_i,
    input  logic [VWID-1:0]    argB_i,
    input  logic [AWID-1:0]    argI_i,
    input  pregno_t            pRt_i,
    input  logic [2:0]         cond_i,
    input  bts_t               bts_i,
    input  logic               bt_i,
    input  logic [AWID-1:0]    ptgt_i,
    input  logic               cjb_i,
    input  logic               bl_i,
    output logic               rdy_o,
    output logic               done_o,
    output rob_ndx_t           done_id_o,
    output logic               taken_o,
    output logic               lnk_we_o,
    output pregno_t            lnk_prn_o,
    output logic [VWID-1:0]    lnk_val_o,
    output logic               rst_req_o,
    output logic [AWID-1:0]    rst_pc_o,
    output checkpt_ndx_t       rst_cp_o,
    output rob_ndx_t           rst_id_o,
    input  logic               rst_ack_i,
    input  logic               flush_i
);

    br_state_t       state;
    logic            cond_hit_c;
    logic            accept_c;
    logic            mis_c;
    logic [AWID-1:0] tgt_c;
    logic [AWID-1:0] ft_c;

    logic            e1_valid;
    logic            e1_nop;
    logic            e1_taken;
    logic            e1_bt;
    logic            e1_link;
    logic [AWID-1:0] e1_tgt;
    logic [AWID-1:0] e1_ft;
    logic [AWID-1:0] e1_ptgt;
    rob_ndx_t        e1_id;
    checkpt_ndx_t    e1_cp;
    pregno_t         e1_prn;

    stark_branch_cmp #(.VWID(VWID)) u_cmp (
        .a     (argA_i),
        .b     (argB_i),
        .cond  (cond_i),
        .hit_c (cond_hit_c)
    );

    assign rdy_o    = !rst && (state != ST_RESTART) && !flush_i;
    assign accept_c = valid_i && rdy_o;
    assign tgt_c    = (cjb_i ? argA_i[AWID-1:0] : pc_i) + argI_i;
    assign ft_c     = pc_i + AWID'(INSN_LEN);

    // E2 prediction check on the op currently held in E1
    assign mis_c = e1_valid && !e1_nop &&
                   ((e1_taken != e1_bt) || (e1_taken && (e1_tgt != e1_ptgt)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            e1_valid  <= 1'b0;
            e1_nop    <= 1'b0;
            e1_taken  <= 1'b0;
            e1_bt     <= 1'b0;
            e1_link   <= 1'b0;
            e1_tgt    <= '0;
            e1_ft     <= '0;
            e1_ptgt   <= '0;
            e1_id     <= '0;
            e1_cp     <= '0;
            e1_prn    <= '0;
            done_o    <= 1'b0;
            done_id_o <= '0;
            taken_o   <= 1'b0;
            lnk_we_o  <= 1'b0;
            lnk_prn_o <= '0;
            lnk_val_o <= '0;
            rst_req_o <= 1'b0;
            rst_pc_o  <= '0;
            rst_cp_o  <= '0;
            rst_id_o  <= '0;
        end else if (flush_i) begin
            state     <= ST_IDLE;
            e1_valid  <= 1'b0;
            done_o    <= 1'b0;
            lnk_we_o  <= 1'b0;
            rst_req_o <= 1'b0;
        end else begin
            // a younger op arriving alongside a mispredict is dropped here
            e1_valid <= accept_c && !mis_c;
            if (accept_c) begin
                e1_nop   <= (bts_i == BTS_NONE);
                e1_taken <= (bts_i != BTS_NONE) && cond_hit_c;
                e1_bt    <= bt_i;
                e1_link  <= (bts_i != BTS_NONE) && bl_i && (pRt_i != '0);
                e1_tgt   <= tgt_c;
                e1_ft    <= ft_c;
                e1_ptgt  <= ptgt_i;
                e1_id    <= id_i;
                e1_cp    <= cp_i;
                e1_prn   <= pRt_i;
            end

            done_o   <= e1_valid;
            lnk_we_o <= e1_valid && e1_link;
            if (e1_valid) begin
                done_id_o <= e1_id;
                taken_o   <= e1_taken;
            end
            if (e1_valid && e1_link) begin
                lnk_prn_o <= e1_prn;
                lnk_val_o <= VWID'(e1_ft);
            end

            if (mis_c) begin
                rst_req_o <= 1'b1;
                rst_pc_o  <= e1_taken ? e1_tgt : e1_ft;
                rst_cp_o  <= e1_cp;
                rst_id_o  <= e1_id;
            end else if ((state == ST_RESTART) && rst_ack_i) begin
                rst_req_o <= 1'b0;
            end

            if (mis_c) begin
                state <= ST_RESTART;
            end else begin
                case (state)
                    ST_IDLE:    if (accept_c) state <= ST_EVAL;
                    ST_EVAL:    if (!accept_c && !e1_valid) state <= ST_IDLE;
                    ST_RESTART: if (rst_ack_i) state <= ST_IDLE;
                    default:    state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stark_branch_resolve.sv
// Self-checking bench for stark_branch_resolve: directed table, corner sequences, random ops.
module tb_stark_branch_resolve;
    import stark_pkg::*;

    logic            clk;
    logic            rst;
    logic            valid_i;
    rob_ndx_t        id_i;
    checkpt_ndx_t    cp_i;
    logic [31:0]     pc_i;
    logic [63:0]     argA_i;
    logic [63:0]     argB_i;
    logic [31:0]     argI_i;
    pregno_t         pRt_i;
    logic [2:0]      cond_i;
    bts_t            bts_i;
    logic            bt_i;
    logic [31:0]     ptgt_i;
    logic            cjb_i;
    logic            bl_i;
    logic            rdy_o;
    logic            done_o;
    rob_ndx_t        done_id_o;
    logic            taken_o;
    logic            lnk_we_o;
    pregno_t         lnk_prn_o;
    logic [63:0]     lnk_val_o;
    logic            rst_req_o;
    logic [31:0]     rst_pc_o;
    checkpt_ndx_t    rst_cp_o;
    rob_ndx_t        rst_id_o;
    logic            rst_ack_i;
    logic            flush_i;

    int errors = 0;
    int checks = 0;
    rob_ndx_t next_id = '0;

    stark_branch_resolve #(.AWID(32), .VWID(64), .INSN_LEN(4)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .id_i(id_i), .cp_i(cp_i),
        .pc_i(pc_i), .argA_i(argA_i), .argB_i(argB_i), .argI_i(argI_i),
        .pRt_i(pRt_i), .cond_i(cond_i), .bts_i(bts_i), .bt_i(bt_i),
        .ptgt_i(ptgt_i), .cjb_i(cjb_i), .bl_i(bl_i), .rdy_o(rdy_o),
        .done_o(done_o), .done_id_o(done_id_o), .taken_o(taken_o),
        .lnk_we_o(lnk_we_o), .lnk_prn_o(lnk_prn_o), .lnk_val_o(lnk_val_o),
        .rst_req_o(rst_req_o), .rst_pc_o(rst_pc_o), .rst_cp_o(rst_cp_o),
        .rst_id_o(rst_id_o), .rst_ack_i(rst_ack_i), .flush_i(flush_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  cond;
        bts_t        bts;
        logic        bt;
        logic [31:0] ptgt;
        logic        cjb;
        logic        bl;
        pregno_t     prt;
        logic [31:0] pc;
        logic [63:0] a;
        logic [63:0] b;
        logic [31:0] imm;
    } op_t;

    typedef struct {
        op_t         op;
        logic        e_tk;
        logic        e_mis;
        logic [31:0] e_rpc;
        logic        e_lwe;
        logic [63:0] e_lval;
    } vec_t;

    vec_t vecs[10];

    function automatic op_t mk(input logic [2:0] cond, input bts_t bts, input logic bt,
                               input logic [31:0] ptgt, input logic cjb, input logic bl,
                               input pregno_t prt, input logic [31:0] pc,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic [31:0] imm);
        op_t o;
        o.cond = cond; o.bts = bts; o.bt = bt; o.ptgt = ptgt; o.cjb = cjb;
        o.bl = bl; o.prt = prt; o.pc = pc; o.a = a; o.b = b; o.imm = imm;
        return o;
    endfunction

    // Reference: branch semantics from plain arithmetic on the architectural fields
    task automatic model(input op_t o, output logic tk, output logic mis,
                         output logic [31:0] rpc, output logic [31:0] tgt,
                         output logic lwe, output logic [63:0] lval);
        logic hold;
        logic [31:0] base;
        logic [31:0] ft;
        case (o.cond)
            3'd0: hold = (o.a == o.b);
            3'd1: hold = (o.a != o.b);
            3'd2: hold = ($signed(o.a) < $signed(o.b));
            3'd3: hold = !($signed(o.a) < $signed(o.b));
            3'd4: hold = (o.a < o.b);
            3'd5: hold = !(o.a < o.b);
            3'd6: hold = 1'b1;
            default: hold = 1'b0;
        endcase
        base = o.cjb ? o.a[31:0] : o.pc;
        tgt  = base + o.imm;
        ft   = o.pc + 32'd4;
        if (o.bts == BTS_NONE) begin
            tk = 1'b0; mis = 1'b0; lwe = 1'b0;
        end else begin
            tk  = hold;
            mis = (tk != o.bt) || (tk && (tgt != o.ptgt));
            lwe = o.bl && (o.prt != 0);
        end
        rpc  = tk ? tgt : ft;
        lval = {32'd0, ft};
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input op_t o, input rob_ndx_t id, input checkpt_ndx_t cp);
        cond_i = o.cond; bts_i = o.bts; bt_i = o.bt; ptgt_i = o.ptgt; cjb_i = o.cjb;
        bl_i = o.bl; pRt_i = o.prt; pc_i = o.pc; argA_i = o.a; argB_i = o.b;
        argI_i = o.imm; id_i = id; cp_i = cp;
    endtask

    // One isolated op: completion at +2 cycles, then restart handshake if expected
    task automatic run_op(input op_t o, input logic e_tk, input logic e_mis,
                          input logic [31:0] e_rpc, input logic e_lwe,
                          input logic [63:0] e_lval, input string tag, input int hold);
        rob_ndx_t id;
        checkpt_ndx_t cp;
        id = next_id;
        next_id = next_id + 5'd1;
        cp = checkpt_ndx_t'($urandom_range(0, 7));
        drive(o, id, cp);
        valid_i = 1'b1;
        #1;
        chk({tag, ".rdy"}, 64'(rdy_o), 64'd1);
        step();
        valid_i = 1'b0;
        chk({tag, ".early"}, 64'(done_o), 64'd0);
        step();
        chk({tag, ".done"}, 64'(done_o), 64'd1);
        chk({tag, ".id"}, 64'(done_id_o), 64'(id));
        chk({tag, ".taken"}, 64'(taken_o), 64'(e_tk));
        chk({tag, ".lnk_we"}, 64'(lnk_we_o), 64'(e_lwe));
        if (e_lwe) begin
            chk({tag, ".lnk_val"}, lnk_val_o, e_lval);
            chk({tag, ".lnk_prn"}, 64'(lnk_prn_o), 64'(o.prt));
        end
        chk({tag, ".rst_req"}, 64'(rst_req_o), 64'(e_mis));
        if (e_mis) begin
            chk({tag, ".rst_pc"}, 64'(rst_pc_o), 64'(e_rpc));
            chk({tag, ".rst_cp"}, 64'(rst_cp_o), 64'(cp));
            chk({tag, ".rst_id"}, 64'(rst_id_o), 64'(id));
            chk({tag, ".rdy_restart"}, 64'(rdy_o), 64'd0);
            for (int h = 0; h < hold; h++) begin
                step();
                chk({tag, ".hold_req"}, 64'(rst_req_o), 64'd1);
                chk({tag, ".hold_pc"}, 64'(rst_pc_o), 64'(e_rpc));
                chk({tag, ".hold_done"}, 64'(done_o), 64'd0);
            end
            rst_ack_i = 1'b1;
            step();
            rst_ack_i = 1'b0;
            chk({tag, ".req_drop"}, 64'(rst_req_o), 64'd0);
            chk({tag, ".rdy_back"}, 64'(rdy_o), 64'd1);
        end else begin
            step();
        end
        chk({tag, ".done_pulse"}, 64'(done_o), 64'd0);
        chk({tag, ".lnk_pulse"}, 64'(lnk_we_o), 64'd0);
    endtask

    initial begin
        op_t o;
        logic tk, mis, lwe;
        logic [31:0] rpc, tgt;
        logic [63:0] lval;
        logic [63:0] pool [6];

        rst = 1'b1; valid_i = 1'b0; rst_ack_i = 1'b0; flush_i = 1'b0;
        drive(mk(3'd0, BTS_NONE, 1'b0, 32'd0, 1'b0, 1'b0, '0, 32'd0, 64'd0, 64'd0, 32'd0),
              '0, '0);

        vecs[0] = '{mk(3'd0, BTS_BCC, 1'b1, 32'h120, 1'b0, 1'b0, 7'd0, 32'h100, 64'd5, 64'd5, 32'h20),
                    1'b1, 1'b0, 32'h0, 1'b0, 64'h0};
        vecs[1] = '{mk(3'd2, BTS_BCC, 1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 32'h1000, '1, 64'd0, 32'h40),
                    1'b1, 1'b1, 32'h1040, 1'b0, 64'h0};
        vecs[2] = '{mk(3'd1, BTS_BCC, 1'b1, 32'h4, 1'b0, 1'b0, 7'd0, 32'hFFFF_FFFC, 64'd3, 64'd3, 32'h8),
                    1'b0, 1'b1, 32'h0, 1'b0, 64'h0};
        vecs[3] = '{mk(3'd6, BTS_JSR, 1'b1, 32'h3010, 1'b1, 1'b1, 7'd7, 32'h2000, 64'h3000, 64'd0, 32'h10),
                    1'b1, 1'b0, 32'h0, 1'b1, 64'h2004};
        vecs[4] = '{mk(3'd6, BTS_NONE, 1'b1, 32'h0, 1'b0, 1'b1, 7'd3, 32'h40, 64'd0, 64'd0, 32'h0),
                    1'b0, 1'b0, 32'h0, 1'b0, 64'h0};
        vecs[5] = '{mk(3'd4, BTS_BCC, 1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 32'h80, '1, 64'd0, 32'h10),
                    1'b0, 1'b0, 32'h0, 1'b0, 64'h0};
        vecs[6] = '{mk(3'd5, BTS_BCC, 1'b1, 32'h600, 1'b0, 1'b0, 7'd0, 32'h500, '1, 64'd0, 32'h10),
                    1'b1, 1'b1, 32'h510, 1'b0, 64'h0};
        vecs[7] = '{mk(3'd7, BTS_BCC, 1'b0, 32'h0, 1'b0, 1'b1, 7'd0, 32'h700, 64'd1, 64'd2, 32'h0),
                    1'b0, 1'b0, 32'h0, 1'b0, 64'h0};
        vecs[8] = '{mk(3'd6, BTS_JMP, 1'b1, 32'h10, 1'b1, 1'b0, 7'd0, 32'h900, 64'h1_FFFF_FFF0, 64'd0, 32'h20),
                    1'b1, 1'b0, 32'h0, 1'b0, 64'h0};
        vecs[9] = '{mk(3'd3, BTS_BCC, 1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 32'h40, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 32'hFFFF_FFF8),
                    1'b1, 1'b1, 32'h38, 1'b0, 64'h0};

        // reset behaviour
        step();
        chk("reset.rdy_in_rst", 64'(rdy_o), 64'd0);
        step();
        rst = 1'b0;
        #1;
        chk("reset.rdy_after", 64'(rdy_o), 64'd1);
        chk("reset.done", 64'(done_o), 64'd0);
        chk("reset.taken", 64'(taken_o), 64'd0);
        chk("reset.lnk_we", 64'(lnk_we_o), 64'd0);
        chk("reset.rst_req", 64'(rst_req_o), 64'd0);
        chk("reset.rst_pc", 64'(rst_pc_o), 64'd0);
        chk("reset.lnk_val", lnk_val_o, 64'd0);
        chk("reset.done_id", 64'(done_id_o), 64'd0);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].e_tk, vecs[i].e_mis, vecs[i].e_rpc,
                   vecs[i].e_lwe, vecs[i].e_lval, $sformatf("vec%0d", i), i % 3);
        end

        // back-to-back, first mispredicts: second is dropped
        drive(vecs[1].op, 5'd20, 3'd2);
        valid_i = 1'b1;
        step();
        drive(vecs[0].op, 5'd21, 3'd3);
        #1;
        chk("b2b.rdy_second", 64'(rdy_o), 64'd1);
        step();
        valid_i = 1'b0;
        chk("b2b.done_first", 64'(done_o), 64'd1);
        chk("b2b.id_first", 64'(done_id_o), 64'd20);
        chk("b2b.req", 64'(rst_req_o), 64'd1);
        chk("b2b.rst_pc", 64'(rst_pc_o), 64'h1040);
        chk("b2b.rdy0", 64'(rdy_o), 64'd0);
        for (int h = 0; h < 2; h++) begin
            step();
            chk("b2b.second_dropped", 64'(done_o), 64'd0);
            chk("b2b.rdy_held", 64'(rdy_o), 64'd0);
            chk("b2b.req_held", 64'(rst_req_o), 64'd1);
        end
        rst_ack_i = 1'b1;
        step();
        rst_ack_i = 1'b0;
        chk("b2b.req_cleared", 64'(rst_req_o), 64'd0);
        chk("b2b.rdy_back", 64'(rdy_o), 64'd1);
        chk("b2b.no_late_done", 64'(done_o), 64'd0);

        // back-to-back, both correct: consecutive completions
        drive(vecs[0].op, 5'd10, 3'd0);
        valid_i = 1'b1;
        step();
        drive(vecs[3].op, 5'd11, 3'd1);
        step();
        valid_i = 1'b0;
        chk("pipe.done1", 64'(done_o), 64'd1);
        chk("pipe.id1", 64'(done_id_o), 64'd10);
        step();
        chk("pipe.done2", 64'(done_o), 64'd1);
        chk("pipe.id2", 64'(done_id_o), 64'd11);
        chk("pipe.lnk_we", 64'(lnk_we_o), 64'd1);
        chk("pipe.lnk_val", lnk_val_o, 64'h2004);
        step();
        chk("pipe.idle", 64'(done_o), 64'd0);

        // flush in RESTART with simultaneous ack
        drive(vecs[1].op, 5'd12, 3'd4);
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        step();
        chk("flushrs.req_up", 64'(rst_req_o), 64'd1);
        flush_i = 1'b1;
        rst_ack_i = 1'b1;
        #1;
        chk("flushrs.rdy_flush", 64'(rdy_o), 64'd0);
        step();
        flush_i = 1'b0;
        rst_ack_i = 1'b0;
        #1;
        chk("flushrs.req_down", 64'(rst_req_o), 64'd0);
        chk("flushrs.no_done", 64'(done_o), 64'd0);
        chk("flushrs.rdy_idle", 64'(rdy_o), 64'd1);
        step();
        chk("flushrs.stay_down", 64'(rst_req_o), 64'd0);

        // flush of an op sitting in E1
        drive(vecs[3].op, 5'd13, 3'd5);
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flushe1.no_done", 64'(done_o), 64'd0);
        chk("flushe1.no_lnk", 64'(lnk_we_o), 64'd0);
        step();
        chk("flushe1.still_none", 64'(done_o), 64'd0);

        // reset mid-operation and during a pending restart
        drive(vecs[6].op, 5'd14, 3'd6);
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid.no_done", 64'(done_o), 64'd0);
        chk("rstmid.no_req", 64'(rst_req_o), 64'd0);
        step();
        chk("rstmid.still_no_done", 64'(done_o), 64'd0);
        drive(vecs[6].op, 5'd15, 3'd7);
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        step();
        chk("rstrs.req_up", 64'(rst_req_o), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rstrs.req_down", 64'(rst_req_o), 64'd0);
        chk("rstrs.rdy", 64'(rdy_o), 64'd1);
        chk("rstrs.rst_pc_zero", 64'(rst_pc_o), 64'd0);

        // randomized ops against the reference model
        pool[0] = 64'd0; pool[1] = 64'd1; pool[2] = '1;
        pool[3] = 64'h8000_0000_0000_0000; pool[4] = 64'h7FFF_FFFF_FFFF_FFFF; pool[5] = 64'd5;
        for (int n = 0; n < 60; n++) begin
            o.cond = 3'($urandom_range(0, 7));
            o.bts  = bts_t'($urandom_range(0, 4));
            o.bt   = 1'($urandom_range(0, 1));
            o.cjb  = 1'($urandom_range(0, 1));
            o.bl   = 1'($urandom_range(0, 1));
            o.prt  = pregno_t'($urandom_range(0, 3));
            o.pc   = {$urandom} & 32'hFFFF_FFFC;
            o.a    = ($urandom_range(0, 2) == 0) ? {$urandom, $urandom} : pool[$urandom_range(0, 5)];
            o.b    = ($urandom_range(0, 2) == 0) ? {$urandom, $urandom} : pool[$urandom_range(0, 5)];
            o.imm  = $urandom;
            o.ptgt = $urandom;
            model(o, tk, mis, rpc, tgt, lwe, lval);
            if ($urandom_range(0, 1) == 1) o.ptgt = tgt;
            model(o, tk, mis, rpc, tgt, lwe, lval);
            run_op(o, tk, mis, rpc, lwe, lval, $sformatf("rand%0d", n), n % 4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stark_branch_resolve.md
STARK_BRANCH_RESOLVE -- requirements
Module: Stark_branch_resolve

Interface
REQ-001 SHALL have parameter AWID, 32, address width (address_t).
REQ-002 SHALL have parameter VWID, 64, value width (value_t).
REQ-003 SHALL have parameter INSN_LEN, 4, fall-through increment in bytes.
REQ-004 SHALL have port clk  in  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port valid_i  in  1  branch station presents an op with all_args_valid.
REQ-007 SHALL have ports id_i (rob_ndx_t), cp_i (checkpt_ndx_t), pc_i (AWID), argA_i/argB_i (VWID), argI_i (AWID), pRt_i (pregno_t)  in  operand/tag inputs.
REQ-008 SHALL have ports cond_i (3), bts_i (bts_t), bt_i (1, predicted taken), ptgt_i (AWID, predicted target), cjb_i (1), bl_i (1)  in  control inputs.
REQ-009 SHALL have port rdy_o  out  1  block accepts valid_i this cycle.
REQ-010 SHALL have ports done_o (1), done_id_o (rob_ndx_t), taken_o (1)  out  ROB completion.
REQ-011 SHALL have ports lnk_we_o (1), lnk_prn_o (pregno_t), lnk_val_o (VWID)  out  link-register writeback.
REQ-012 SHALL have ports rst_req_o (1), rst_pc_o (AWID), rst_cp_o (checkpt_ndx_t), rst_id_o (rob_ndx_t)  out  mispredict restart request.
REQ-013 SHALL have ports rst_ack_i  in  1  front end accepted restart; flush_i  in  1  discard in-flight ops.

Function
REQ-014 SHALL be a two-stage pipeline: E1 (compare, target add) registered, E2 (mispredict check, outputs) registered; done_o 2 cycles after accepted valid_i.
REQ-015 SHALL accept an op when valid_i && rdy_o; rdy_o = (state != RESTART) && !flush_i.
REQ-016 SHALL evaluate cond_i: 0 EQ, 1 NE, 2 LT signed, 3 GE signed, 4 LTU, 5 GEU, 6 ALWAYS, 7 NEVER, on argA_i vs argB_i full VWID.
REQ-017 SHALL compute target = (cjb_i ? argA_i[AWID-1:0] : pc_i) + argI_i, modulo 2^AWID (wrap, no carry out).
REQ-018 SHALL compute fall-through = pc_i + INSN_LEN modulo 2^AWID.
REQ-019 SHALL treat bts_i == BTS_NONE as a NOP: done_o asserted, taken_o 0, no link write, no restart.
REQ-020 SHALL assert lnk_we_o for one cycle with lnk_val_o = zero-extended fall-through when bl_i and pRt_i != 0.
REQ-021 SHALL flag mispredict when taken != bt_i, or taken && bt_i && target != ptgt_i.
REQ-022 SHALL on mispredict set rst_pc_o = taken ? target : fall-through, rst_cp_o = cp_i, rst_id_o = id_i.
REQ-023 SHALL implement FSM IDLE -> EVAL on accept; EVAL -> IDLE when pipe empty and no mispredict; EVAL -> RESTART on mispredict in E2; RESTART -> IDLE on rst_ack_i.
REQ-024 SHALL hold rst_req_o and its payload stable from RESTART entry until rst_ack_i sampled high; rst_ack_i in same cycle as entry ends request next cycle.
REQ-025 SHALL discard a younger op in E1 when E2 raises mispredict (no done_o, no link write for it).
REQ-026 SHALL on flush_i clear E1/E2 valid, drop pending restart, return to IDLE next cycle; flush_i overrides simultaneous mispredict and rst_ack_i.
REQ-027 SHALL assert done_o for mispredicting branch in the same cycle rst_req_o first rises.

Reset
REQ-028 SHALL on rst: state IDLE, pipeline valids 0, done_o/lnk_we_o/rst_req_o/taken_o 0, all payload outputs 0, rdy_o 0 during rst, 1 the cycle after.
REQ-029 SHALL abandon any in-flight op or pending restart on rst mid-operation without emitting done_o.

Structure
REQ-030 SHALL place branch cond encoding enum, bts_t, and INSN_LEN constant in Stark_pkg.
REQ-031 SHALL contain one sub-module Stark_branch_cmp (combinational cond evaluator, VWID-wide).

Verification
REQ-032 SHALL cover: BEQ argA=argB=5, bt_i=1, ptgt correct -> done_o at +2, taken_o 1, no rst_req_o.
REQ-033 SHALL cover: BLT argA=-1, argB=0, bt_i=0, pc=0x1000, argI=0x40 -> rst_req_o, rst_pc_o=0x1040, held until rst_ack_i.
REQ-034 SHALL cover: BNE not taken, bt_i=1, pc=0xFFFFFFFC -> rst_pc_o=0x00000000 (wrap).
REQ-035 SHALL cover: JSR bl_i=1, pRt=7, pc=0x2000 -> lnk_we_o 1 cycle, lnk_val_o=0x2004.
REQ-036 SHALL cover: back-to-back ops, first mispredicts -> second dropped, rdy_o 0 until rst_ack_i.
REQ-037 SHALL cover: flush_i in RESTART with rst_ack_i high -> rst_req_o 0 next cycle, state IDLE, no done_o.
